// File: rtl/siso_tx_ctrl.sv
// Parallel-to-serial transmit controller: accepts a word over valid/ready, shifts
// it out one bit per clock with shift/frame strobes, then holds a fixed idle gap.
module siso_tx_ctrl #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             shift_en,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH) + 1;
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [BCW-1:0]   r_bitcnt;
  logic [BCW-1:0]   w_bitcnt_nxt;
  logic [GCW-1:0]   r_gapcnt;
  logic [GCW-1:0]   w_gapcnt_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_shift_en;
  logic             w_shift_en_nxt;
  logic             r_frame;
  logic             w_frame_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // Bit that leaves the word next, and the word with that bit removed.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bitcnt_nxt   = r_bitcnt;
    w_gapcnt_nxt   = r_gapcnt;
    w_sout_nxt     = 1'b0;
    w_shift_en_nxt = 1'b0;
    w_frame_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (din_valid) begin
          // The shift register holds the word already advanced past the bit on sout.
          w_state_nxt    = ST_SHIFT;
          w_shreg_nxt    = shift_word(din);
          w_sout_nxt     = first_bit(din);
          w_shift_en_nxt = 1'b1;
          w_frame_nxt    = 1'b1;
          w_busy_nxt     = 1'b1;
          w_bitcnt_nxt   = BCW'(1);
        end
      end

      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (r_bitcnt == LAST_BIT) begin
          w_bitcnt_nxt = '0;
          w_done_nxt   = 1'b1;
          if (GAP > 0) begin
            w_state_nxt  = ST_GAP;
            w_gapcnt_nxt = GCW'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_sout_nxt     = first_bit(r_shreg);
          w_shreg_nxt    = shift_word(r_shreg);
          w_shift_en_nxt = 1'b1;
          w_bitcnt_nxt   = r_bitcnt + BCW'(1);
        end
      end

      ST_GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gapcnt == LAST_GAP) begin
          w_state_nxt  = ST_IDLE;
          w_busy_nxt   = 1'b0;
          w_gapcnt_nxt = '0;
        end else begin
          w_gapcnt_nxt = r_gapcnt + GCW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_gapcnt   <= '0;
      r_sout     <= 1'b0;
      r_shift_en <= 1'b0;
      r_frame    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_gapcnt   <= w_gapcnt_nxt;
      r_sout     <= w_sout_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_frame    <= w_frame_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign din_ready = (r_state == ST_IDLE);
  assign sout      = r_sout;
  assign shift_en  = r_shift_en;
  assign frame     = r_frame;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Directed bench for siso_tx_ctrl: instance A (GAP=2, MSB first), instance B (GAP=0, LSB first).
module tb_siso_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, sout_a, sh_a, fr_a, busy_a, done_a;
  logic       rdy_b, sout_b, sh_b, fr_b, busy_b, done_b;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  siso_tx_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .sout(sout_a), .shift_en(sh_a), .frame(fr_a), .busy(busy_a), .done(done_a)
  );

  siso_tx_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .sout(sout_b), .shift_en(sh_b), .frame(fr_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got={sout,sh,fr,busy,done,rdy}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs(input bit sel_b);
    if (sel_b) return {sout_b, sh_b, fr_b, busy_b, done_b, rdy_b};
    return {sout_a, sh_a, fr_a, busy_a, done_a, rdy_a};
  endfunction

  // Expected {sout,shift_en,frame,busy,done,din_ready} in cycle c after accepting word.
  function automatic logic [5:0] exp_vec(input int c, input logic [7:0] word,
                                         input int gap, input bit msb);
    logic b;
    if (c < 8) begin
      b = msb ? word[7-c] : word[c];
      return {b, 1'b1, (c == 0), 1'b1, 1'b0, 1'b0};
    end
    if (c == 8) return {1'b0, 1'b0, 1'b0, (gap > 0), 1'b1, (gap == 0)};
    if (c < 8 + gap) return 6'b000100;
    return 6'b000001;
  endfunction

  initial begin
    rst = 1'b0; vld_a = 1'b1; din_a = 8'hFF; vld_b = 1'b1; din_b = 8'hFF;

    // Test 1: reset held with a word offered; nothing captured.
    step();
    chk("t1_rst_e1_a", obs(0), 6'b000001);
    chk("t1_rst_e1_b", obs(1), 6'b000001);
    step();
    chk("t1_rst_e2_a", obs(0), 6'b000001);
    chk("t1_rst_e2_b", obs(1), 6'b000001);
    vld_a = 1'b0; vld_b = 1'b0; rst = 1'b1;
    step();
    chk("t1_post_a", obs(0), 6'b000001);
    chk("t1_post_b", obs(1), 6'b000001);

    // Test 2: single word 0xA5, GAP=2, MSB first.
    din_a = 8'hA5; vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("t2_c%0d", c), obs(0), exp_vec(c, 8'hA5, 2, 1'b1));
      step();
    end

    // Test 3: back-to-back 0x81 then 0x3C with valid held.
    din_a = 8'h81; vld_a = 1'b1;
    step();
    din_a = 8'h3C;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("t3a_c%0d", c), obs(0), exp_vec(c, 8'h81, 2, 1'b1));
      step();
    end
    vld_a = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("t3b_c%0d", c), obs(0), exp_vec(c, 8'h3C, 2, 1'b1));
      step();
    end

    // Test 4: LSB first, GAP=0, 0x01 then 0x80 accepted in the done cycle.
    din_b = 8'h01; vld_b = 1'b1;
    step();
    vld_b = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("t4a_c%0d", c), obs(1), exp_vec(c, 8'h01, 0, 1'b0));
      if (c == 8) begin
        din_b = 8'h80; vld_b = 1'b1;
      end
      step();
    end
    vld_b = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      chk($sformatf("t4b_c%0d", c), obs(1), exp_vec(c, 8'h80, 0, 1'b0));
      step();
    end

    // Test 5: valid toggling and din changing while busy are ignored.
    din_a = 8'hA5; vld_a = 1'b1;
    step();
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("t5_c%0d", c), obs(0), exp_vec(c, 8'hA5, 2, 1'b1));
      din_a = 8'h00;
      vld_a = (c < 8) && (c % 2 == 0);
      step();
    end
    chk("t5_noacc", obs(0), 6'b000001);

    // Test 6: reset at E3 mid-word, then reset coinciding with accept, then clean word.
    din_a = 8'hF0; vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      chk($sformatf("t6a_c%0d", c), obs(0), exp_vec(c, 8'hF0, 2, 1'b1));
      if (c == 2) rst = 1'b0;
      step();
    end
    chk("t6_rst_c3", obs(0), 6'b000001);
    rst = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      step();
      chk($sformatf("t6_nodone_c%0d", c), obs(0), 6'b000001);
    end
    rst = 1'b0; din_a = 8'hF0; vld_a = 1'b1;
    step();
    chk("t6_rst_vs_accept", obs(0), 6'b000001);
    rst = 1'b1;
    step();
    vld_a = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("t6b_c%0d", c), obs(0), exp_vec(c, 8'hF0, 2, 1'b1));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/siso_tx_ctrl.md
Name: siso_tx_ctrl

Overview:
Serializer controller that sequences a serial-in/serial-out shift path. It accepts a parallel word over a valid/ready handshake and emits it one bit per clock on sout. It also drives a shift enable and framing strobes so a downstream SISO chain or receiver can sample the stream. It sits between a parallel producer and the serial shift-register datapath, and enforces a programmable inter-word gap.

Parameters:
WIDTH, 8, bits per word; must be at least 2.
GAP, 1, number of forced idle cycles after the last bit, before the block returns to IDLE; 0 is legal.
MSB_FIRST, 1, 1 sends din[WIDTH-1] first; 0 sends din[0] first.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
din  input  WIDTH  parallel word to transmit.
din_valid  input  1  producer has a word on din.
din_ready  output  1  controller can accept a word; equals (state == IDLE).
sout  output  1  serial data out; registered.
shift_en  output  1  high exactly while a valid bit is on sout; registered.
frame  output  1  high only while the first bit of a word is on sout; registered.
busy  output  1  state != IDLE; registered.
done  output  1  one-cycle pulse in the cycle after the last bit; registered.

Behaviour:
- Reset: rst == 0 at a rising edge forces the following.
  - state = IDLE, bit counter = 0, gap counter = 0, shift register = 0.
  - sout = 0, shift_en = 0, frame = 0, busy = 0, done = 0.
  - din_ready = 1 from the cycle after the reset edge.
- States and transitions:
  - IDLE: go to SHIFT on an edge where din_valid = 1 (din_ready is 1 by definition).
  - SHIFT: go to GAP after WIDTH bits if GAP > 0, otherwise go to IDLE.
  - GAP: go to IDLE after GAP cycles.
- Cycle numbering: cycle c is the interval after edge Ec. Accept edge E0 is the edge with din_valid = 1 in IDLE.
- At E0:
  - din is captured into the shift register.
  - sout = first bit, shift_en = 1, frame = 1, busy = 1.
  - bit counter = 1.
- Edges E1 .. E(WIDTH-1):
  - The next bit is placed on sout, shifting left for MSB_FIRST and right otherwise.
  - frame = 0, shift_en stays 1.
  - Result: bits occupy cycles 0 .. WIDTH-1.
- Edge E(WIDTH):
  - sout = 0, shift_en = 0, done = 1.
  - If GAP > 0, go to GAP and set busy = 1; otherwise go to IDLE and set busy = 0.
- GAP state:
  - Occupies cycles WIDTH .. WIDTH+GAP-1.
  - sout = 0, shift_en = 0, done = 0 after its first cycle, din_ready = 0.
- Return to IDLE: IDLE is reached in cycle WIDTH+GAP.
- Back-to-back words: the earliest next accept edge is E(WIDTH+GAP+1). The next first bit appears in cycle WIDTH+GAP+1, so there are exactly GAP+1 idle sout cycles between words.
- Handshake rules:
  - Transfer happens only when din_valid & din_ready at the edge.
  - din_valid or din changes while busy are ignored; no capture and no queuing.
  - The producer holds din and din_valid until the transfer.
  - din is not sampled after E0.
- Counters:
  - Bit counter width is $clog2(WIDTH)+1. It wraps to 0 when leaving SHIFT.
  - Gap counter width is $clog2(GAP+1); it is unused when GAP = 0.
- Reset mid-word or mid-gap:
  - The word is discarded and all outputs are 0 after the reset edge.
  - No done pulse is produced.
  - A reset on the same edge as an accept wins; the word is not captured.
- Idle outputs: sout stays 0 when not shifting; the line idles low.

Test Plan:
1. Reset values: hold rst = 0 for 2 edges with din_valid = 1 and din = 8'hFF -> sout/shift_en/frame/busy/done all 0, no capture; after release, din_ready = 1.
2. Single word, WIDTH = 8, GAP = 2, MSB_FIRST = 1: accept 8'hA5 at E0.
   - sout in cycles 0..7 = 1,0,1,0,0,1,0,1.
   - frame = 1 only in cycle 0; shift_en = 1 in cycles 0..7.
   - done = 1 in cycle 8 only; busy = 1 in cycles 0..9; din_ready = 1 again in cycle 10.
3. Back-to-back, GAP = 2: hold din_valid with 8'h81 then 8'h3C -> second word accepted at E11; its first bit (0) is in cycle 11; sout = 0 in cycles 8..10.
4. LSB-first, MSB_FIRST = 0, din = 8'h01 -> sout = 1,0,0,0,0,0,0,0 in cycles 0..7. With GAP = 0: done and din_ready are both 1 in cycle 8; an accept at E9 starts the next word in cycle 9.
5. Valid while busy: during SHIFT, toggle din_valid and change din to 8'h00 -> transmitted bits are unchanged and there is no extra accept.
6. Reset mid-word: assert rst = 0 at E3 -> in cycle 3 all outputs are 0 and there is no done. After release, accepting 8'hF0 transmits cleanly: 1,1,1,1,0,0,0,0.
